// File: rtl/gpr_wb_pkg.sv
// Shared register-file constants and the queued writeback entry type.
// Imported by the writeback queue, its interface and the sequencer.
package gpr_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREG  = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic wb_entry_t make_entry(input logic [REG_W-1:0] rd,
                                           input logic [XLEN-1:0] data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/gpr_wb_if.sv
// Bundle of result-producer handshakes, register-file write port and decode lookups
// around the writeback sequencer. The slave modport is the sequencer's view.
interface gpr_wb_if;
  import gpr_pkg::*;

  logic             lsu_valid;
  logic [REG_W-1:0] lsu_rd;
  logic [XLEN-1:0]  lsu_data;
  logic             lsu_ready;
  logic             alu_valid;
  logic [REG_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ready;
  logic             wb_hold;
  logic             gpr_we;
  logic [REG_W-1:0] gpr_rd;
  logic [XLEN-1:0]  gpr_di;
  logic [NREG-1:0]  pend;
  logic [REG_W-1:0] fwd_ra;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_data;

  modport master (
    output lsu_valid, lsu_rd, lsu_data, alu_valid, alu_rd, alu_data, wb_hold, fwd_ra,
    input  lsu_ready, alu_ready, gpr_we, gpr_rd, gpr_di, pend, fwd_hit, fwd_data
  );

  modport slave (
    input  lsu_valid, lsu_rd, lsu_data, alu_valid, alu_rd, alu_data, wb_hold, fwd_ra,
    output lsu_ready, alu_ready, gpr_we, gpr_rd, gpr_di, pend, fwd_hit, fwd_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Generic circular FIFO that also exposes every slot in age order (index 0 = head)
// so the owner can run scoreboard and forwarding compares over live entries.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             age_valid [DEPTH],
  output logic [WIDTH-1:0] age_data  [DEPTH]
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slots beyond count are never reported as valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  assign head_data = mem[head];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_valid[k] = CNT_W'(k) < count;
      age_data[k]  = mem[head + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/gpr_wb.sv
// Writeback sequencer: arbitrates LSU/ALU results into an in-order queue, drains one
// register-file write per cycle, and publishes pending-write and forwarding lookups.
module gpr_wb
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  gpr_wb_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             not_full;
  logic             lsu_fire;
  logic             alu_fire;
  logic             push;
  logic             pop;
  wb_entry_t        push_entry;
  logic [ENTRY_W-1:0] head_raw;
  wb_entry_t        head_entry;
  logic [CNT_W-1:0] count;
  logic             age_valid [DEPTH];
  logic [ENTRY_W-1:0] age_data [DEPTH];
  wb_entry_t        scan;

  // Readiness looks only at occupancy, so a full queue never accepts on a same-cycle pop.
  assign not_full      = count < CNT_W'(DEPTH);
  assign bus.lsu_ready = rst_n && not_full;
  assign bus.alu_ready = rst_n && not_full && !bus.lsu_valid;
  assign lsu_fire      = bus.lsu_valid && bus.lsu_ready;
  assign alu_fire      = bus.alu_valid && bus.alu_ready;

  assign push_entry = lsu_fire ? make_entry(bus.lsu_rd, bus.lsu_data)
                               : make_entry(bus.alu_rd, bus.alu_data);
  assign push       = (lsu_fire || alu_fire) && (push_entry.rd != '0);

  assign pop        = (count != '0) && !bus.wb_hold;
  assign head_entry = wb_entry_t'(head_raw);

  assign bus.gpr_we = pop;
  assign bus.gpr_rd = (count != '0) ? head_entry.rd   : '0;
  assign bus.gpr_di = (count != '0) ? head_entry.data : '0;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (push_entry),
    .pop       (pop),
    .head_data (head_raw),
    .count     (count),
    .age_valid (age_valid),
    .age_data  (age_data)
  );

  // Scan oldest to youngest so the last match left standing is the youngest write.
  always_comb begin
    bus.pend     = '0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    scan         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan = wb_entry_t'(age_data[k]);
      if (age_valid[k]) begin
        bus.pend[scan.rd] = 1'b1;
        if (scan.rd == bus.fwd_ra && bus.fwd_ra != '0) begin
          bus.fwd_hit  = 1'b1;
          bus.fwd_data = scan.data;
        end
      end
    end
    bus.pend[0] = 1'b0;
  end

endmodule
